neuron_stream_driver: RTL and testbench

NEURON_STREAM_DRIVER -- requirements
Module: neuron_stream_driver

---
 rtl/neuron_stream_driver_pkg.sv | 33 +++
 rtl/ndrv_buffer.sv | 45 ++++
 rtl/neuron_stream_driver.sv | 142 ++++++++++++++
 tb/tb_neuron_stream_driver.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_stream_driver_pkg.sv
// Shared definitions for the neuron stream driver: FSM states, weight codes,
// neuron uio bit positions and the buffered element layout.
package neuron_stream_driver_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [1:0] W_ZERO = 2'b00;
    localparam logic [1:0] W_POS  = 2'b01;
    localparam logic [1:0] W_NEG  = 2'b11;

    localparam int VALID     = 2;
    localparam int LAST      = 3;
    localparam int OUT_VALID = 4;

    // Width of the element count; it must be able to hold DEPTH itself.
    localparam int CNT_W = 5;

    typedef struct packed {
        logic [7:0] act;
        logic [1:0] wgt;
    } elem_t;

    // The reserved code 2'b10 has no meaning to the neuron, so it is stored as zero.
    function automatic logic [1:0] sanitize_wgt(input logic [1:0] code);
        return (code == W_POS || code == W_NEG) ? code : W_ZERO;
    endfunction

endpackage

// File: rtl/ndrv_buffer.sv
// Element buffer: DEPTH entries of {act, wgt}, filled in order by a write
// pointer and drained in order by a read index; both return to zero on clear.
module ndrv_buffer
    import neuron_stream_driver_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  elem_t            i_wr_data,
    input  logic             i_clr,
    input  logic             i_rd_adv,
    output logic [CNT_W-1:0] o_count,
    output logic [CNT_W-1:0] o_rd_idx,
    output elem_t            o_rd_data
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_rd_idx;
    elem_t            r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count  <= '0;
            r_rd_idx <= '0;
        end else begin
            if (i_wr_en)  r_count  <= r_count + 1'b1;
            if (i_rd_adv) r_rd_idx <= r_rd_idx + 1'b1;
        end
    end

    // NOTE: the storage array has no reset; entries are only read below r_count,
    // which reset and clear zero, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (i_wr_en) r_mem[r_count[AW-1:0]] <= i_wr_data;
    end

    assign o_count   = r_count;
    assign o_rd_idx  = r_rd_idx;
    assign o_rd_data = r_mem[r_rd_idx[AW-1:0]];

endmodule

// File: rtl/neuron_stream_driver.sv
// Buffers host-written {activation, ternary weight} pairs, streams them to a
// neuron one per cycle on start, then waits for its result or times out.
module neuron_stream_driver
    import neuron_stream_driver_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [7:0]       wr_act,
    input  logic [1:0]       wr_wgt,
    input  logic             start,
    output logic             busy,
    output logic [CNT_W-1:0] count,
    output logic [7:0]       nrn_ui,
    output logic [7:0]       nrn_uio,
    input  logic [7:0]       nrn_uo,
    input  logic [7:0]       nrn_uio_out,
    output logic             res_valid,
    output logic [7:0]       res_data,
    output logic             res_timeout
);

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [7:0]       TMO_LAST = 8'(TIMEOUT - 1);

    state_e           r_state;
    state_e           w_next;
    logic [7:0]       r_tmo;
    logic             w_wr_fire;
    logic             w_beat;
    logic             w_last;
    logic             w_capture;
    logic             w_expire;
    logic [CNT_W-1:0] w_count;
    logic [CNT_W-1:0] w_count_eff;
    logic [CNT_W-1:0] w_rd_idx;
    elem_t            w_rd_data;
    logic [7:0]       w_uio;
    logic             w_unused_ok;

    assign busy      = (r_state != IDLE);
    assign wr_ready  = (r_state == IDLE) && (w_count < DEPTH_C);
    assign w_wr_fire = wr_valid && wr_ready;
    assign count     = w_count;

    // A write accepted alongside start becomes the final streamed element.
    assign w_count_eff = w_count + {{(CNT_W-1){1'b0}}, w_wr_fire};
    assign w_last      = (w_rd_idx + 1'b1 == w_count_eff);

    ndrv_buffer #(.DEPTH(DEPTH)) u_buffer (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr_fire),
        .i_wr_data ('{act: wr_act, wgt: sanitize_wgt(wr_wgt)}),
        .i_clr     (w_capture || w_expire),
        .i_rd_adv  (w_beat),
        .o_count   (w_count),
        .o_rd_idx  (w_rd_idx),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        w_next    = r_state;
        w_beat    = 1'b0;
        w_capture = 1'b0;
        w_expire  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start && w_count != '0) begin
                    w_next = SEND;
                    w_beat = 1'b1;
                end
            end
            SEND: begin
                if (w_rd_idx < w_count) w_beat = 1'b1;
                else                    w_next = WAIT;
            end
            WAIT: begin
                if (nrn_uio_out[OUT_VALID]) begin
                    w_capture = 1'b1;
                    w_next    = DONE;
                end else if (r_tmo == TMO_LAST) begin
                    w_expire = 1'b1;
                    w_next   = IDLE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_uio          = '0;
        w_uio[1:0]     = w_rd_data.wgt;
        w_uio[VALID]   = 1'b1;
        w_uio[LAST]    = w_last;
    end

    // NOTE: state-holding logic uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            nrn_ui      <= '0;
            nrn_uio     <= '0;
            res_valid   <= 1'b0;
            res_timeout <= 1'b0;
            res_data    <= '0;
            r_tmo       <= '0;
        end else begin
            res_valid   <= w_capture;
            res_timeout <= w_expire;
            if (w_capture)     res_data <= nrn_uo;
            else if (w_expire) res_data <= '0;

            if (w_beat) begin
                nrn_ui  <= w_rd_data.act;
                nrn_uio <= w_uio;
            end else begin
                nrn_ui  <= '0;
                nrn_uio <= '0;
            end

            if (r_state == WAIT && !w_capture && !w_expire) r_tmo <= r_tmo + 1'b1;
            else                                             r_tmo <= '0;
        end
    end

    // Only out_valid is meaningful on the neuron's uio_out bus.
    assign w_unused_ok = ^{nrn_uio_out[7:5], nrn_uio_out[3:0]};

endmodule

// File: tb/tb_neuron_stream_driver.sv
// Directed self-checking bench for neuron_stream_driver.
module tb_neuron_stream_driver;

    localparam int DEPTH = 16;
    localparam int TMO   = 255;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [7:0] wr_act = '0;
    logic [1:0] wr_wgt = '0;
    logic       start = 1'b0;
    logic       busy;
    logic [4:0] count;
    logic [7:0] nrn_ui;
    logic [7:0] nrn_uio;
    logic [7:0] nrn_uo = '0;
    logic [7:0] nrn_uio_out = '0;
    logic       res_valid;
    logic [7:0] res_data;
    logic       res_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    neuron_stream_driver #(.DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_act      (wr_act),
        .wr_wgt      (wr_wgt),
        .start       (start),
        .busy        (busy),
        .count       (count),
        .nrn_ui      (nrn_ui),
        .nrn_uio     (nrn_uio),
        .nrn_uo      (nrn_uo),
        .nrn_uio_out (nrn_uio_out),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .res_timeout (res_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled mid-cycle, away from the rising edge.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic write_el(input logic [7:0] a, input logic [1:0] w);
        wr_valid = 1'b1;
        wr_act   = a;
        wr_wgt   = w;
        cyc();
        wr_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        logic seen;

        // Reset state
        cyc(); cyc();
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_count", count, 0);
        check("rst_ui", nrn_ui, 0);
        check("rst_uio", nrn_uio, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_timeout", res_timeout, 0);
        check("rst_res_data", res_data, 0);
        check("rst_wr_ready", wr_ready, 1);

        // Three elements, then a result two cycles after the last beat
        write_el(8'd5, 2'b01);
        write_el(8'hFD, 2'b11);
        write_el(8'd7, 2'b00);
        check("s3_count", count, 3);
        pulse_start();
        wr_valid = 1'b1; wr_act = 8'h99; wr_wgt = 2'b01;
        check("s3_b0_ui", nrn_ui, 8'h05);
        check("s3_b0_uio", nrn_uio, 8'h05);
        check("s3_b0_busy", busy, 1);
        check("s3_b0_wr_ready", wr_ready, 0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("s3_b1_ui", nrn_ui, 8'hFD);
        check("s3_b1_uio", nrn_uio, 8'h07);
        cyc();
        wr_valid = 1'b0;
        check("s3_b2_ui", nrn_ui, 8'h07);
        check("s3_b2_uio", nrn_uio, 8'h0C);
        check("s3_b2_count", count, 3);
        cyc();
        check("s3_w0_uio", nrn_uio, 0);
        check("s3_w0_ui", nrn_ui, 0);
        check("s3_w0_busy", busy, 1);
        cyc();
        check("s3_w1_res_valid", res_valid, 0);
        nrn_uio_out = 8'h10; nrn_uo = 8'h08;
        cyc();
        nrn_uio_out = 8'h00; nrn_uo = 8'h00;
        check("s3_done_res_valid", res_valid, 1);
        check("s3_done_res_data", res_data, 8'h08);
        check("s3_done_count", count, 0);
        check("s3_done_busy", busy, 1);
        cyc();
        check("s3_after_res_valid", res_valid, 0);
        check("s3_after_busy", busy, 0);
        check("s3_after_res_data", res_data, 8'h08);

        // out_valid in IDLE is ignored and res_data holds
        nrn_uio_out = 8'h10; nrn_uo = 8'h77;
        cyc();
        nrn_uio_out = 8'h00; nrn_uo = 8'h00;
        check("idle_ov_res_valid", res_valid, 0);
        check("idle_ov_res_data", res_data, 8'h08);
        check("idle_ov_busy", busy, 0);

        // Fill to DEPTH, attempt one more, stream everything, then time out
        for (int i = 0; i < DEPTH; i++) write_el(8'(i + 1), 2'b01);
        check("full_count", count, DEPTH);
        check("full_wr_ready", wr_ready, 0);
        write_el(8'h55, 2'b11);
        check("full_17th_count", count, DEPTH);
        pulse_start();
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("full_b%0d_ui", i), nrn_ui, i + 1);
            check($sformatf("full_b%0d_uio", i), nrn_uio, (i == DEPTH - 1) ? 8'h0D : 8'h05);
            cyc();
        end
        check("full_w0_uio", nrn_uio, 0);
        check("full_w0_ui", nrn_ui, 0);
        seen = 1'b0;
        for (int k = 1; k < TMO; k++) begin
            cyc();
            if (res_timeout || res_valid || !busy) seen = 1'b1;
        end
        check("tmo_early_event", seen, 0);
        cyc();
        check("tmo_pulse", res_timeout, 1);
        check("tmo_res_data", res_data, 0);
        check("tmo_res_valid", res_valid, 0);
        check("tmo_busy", busy, 0);
        check("tmo_count", count, 0);
        cyc();
        check("tmo_pulse_end", res_timeout, 0);

        // Reserved weight code travels as zero
        write_el(8'h22, 2'b10);
        pulse_start();
        check("w10_ui", nrn_ui, 8'h22);
        check("w10_uio", nrn_uio, 8'h0C);
        cyc();
        nrn_uio_out = 8'h10; nrn_uo = 8'hA5;
        cyc();
        nrn_uio_out = 8'h00; nrn_uo = 8'h00;
        check("w10_res_valid", res_valid, 1);
        check("w10_res_data", res_data, 8'hA5);
        cyc();

        // Write alongside start, then out_valid on the very cycle the timeout expires
        write_el(8'h01, 2'b01);
        wr_valid = 1'b1; wr_act = 8'h02; wr_wgt = 2'b11;
        pulse_start();
        wr_valid = 1'b0;
        check("cw_b0_ui", nrn_ui, 8'h01);
        check("cw_b0_uio", nrn_uio, 8'h05);
        cyc();
        check("cw_b1_ui", nrn_ui, 8'h02);
        check("cw_b1_uio", nrn_uio, 8'h0F);
        check("cw_b1_count", count, 2);
        cyc();
        check("cw_w0_uio", nrn_uio, 0);
        seen = 1'b0;
        for (int k = 1; k < TMO; k++) begin
            cyc();
            if (res_timeout || res_valid) seen = 1'b1;
        end
        check("tie_early_event", seen, 0);
        nrn_uio_out = 8'h10; nrn_uo = 8'h3C;
        cyc();
        nrn_uio_out = 8'h00; nrn_uo = 8'h00;
        check("tie_res_valid", res_valid, 1);
        check("tie_res_timeout", res_timeout, 0);
        check("tie_res_data", res_data, 8'h3C);
        cyc();
        check("tie_after_busy", busy, 0);
        check("tie_after_timeout", res_timeout, 0);

        // Reset in the middle of a five-element stream
        for (int i = 0; i < 5; i++) write_el(8'(10 + i), 2'b01);
        pulse_start();
        check("rs_b0_ui", nrn_ui, 8'd10);
        cyc();
        check("rs_b1_ui", nrn_ui, 8'd11);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("rs_uio", nrn_uio, 0);
        check("rs_ui", nrn_ui, 0);
        check("rs_count", count, 0);
        check("rs_busy", busy, 0);
        check("rs_res_data", res_data, 0);
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (res_valid || res_timeout || busy || nrn_uio != 0) seen = 1'b1;
            cyc();
        end
        check("rs_no_activity", seen, 0);

        // start with an empty buffer is ignored
        pulse_start();
        check("empty_start_busy", busy, 0);
        cyc();
        check("empty_start_busy2", busy, 0);
        check("empty_start_uio", nrn_uio, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
